// File: rtl/kbest_result_reader.sv
// Drains the per-query k-best result arrays through read port 1 and serializes
// each query's K distance/index pairs onto a valid/ready stream, one slot per beat.
module kbest_result_reader #(
  parameter int  DATA_WIDTH  = 11,
  parameter int  K           = 4,
  parameter int  NUM_QUERIES = 256,
  localparam int RW          = $clog2(K)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    csb1,
  output logic [7:0]              addr1,
  input  logic [K*DATA_WIDTH-1:0] rdist_1,
  input  logic [K*9-1:0]          rindices_1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_query,
  output logic [RW-1:0]           out_rank,
  output logic [DATA_WIDTH-1:0]   out_dist,
  output logic [8:0]              out_index,
  output logic                    out_last
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [7:0]    Q_LAST = 8'(NUM_QUERIES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(K - 1);

  state_t                  state_q, state_d;
  logic [7:0]              q_q, q_d;
  logic [RW-1:0]           r_q, r_d;
  logic [DATA_WIDTH-1:0]   dist_buf_q [K];
  logic [8:0]              idx_buf_q  [K];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  // The array presents data for addr1 one cycle after the READ strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < K; s++) begin
        dist_buf_q[s] <= '0;
        idx_buf_q[s]  <= '0;
      end
    end else if (state_q == CAPTURE) begin
      for (int s = 0; s < K; s++) begin
        dist_buf_q[s] <= rdist_1[s*DATA_WIDTH +: DATA_WIDTH];
        idx_buf_q[s]  <= rindices_1[s*9 +: 9];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          q_d     = '0;
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        r_d     = '0;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (r_q != R_LAST) begin
            r_d = r_q + 1'b1;
          end else if (q_q != Q_LAST) begin
            q_d     = q_q + 8'd1;
            state_d = READ;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stream fields come straight from registers, so they hold while stalled.
  assign busy      = (state_q != IDLE) && (state_q != FINISH);
  assign done      = (state_q == FINISH);
  assign csb1      = (state_q != READ);
  assign addr1     = q_q;
  assign out_valid = (state_q == SEND);
  assign out_query = q_q;
  assign out_rank  = r_q;
  assign out_dist  = dist_buf_q[r_q];
  assign out_index = idx_buf_q[r_q];
  assign out_last  = (state_q == SEND) && (q_q == Q_LAST) && (r_q == R_LAST);

endmodule

// File: tb/tb_kbest_result_reader.sv
// Randomized scoreboard bench for kbest_result_reader: full drains with random
// backpressure, start spamming, mid-pass reset, and a tiny K=2/1-query instance.
module tb_kbest_result_reader;
  localparam int DW = 11;
  localparam int KK = 4;
  localparam int NQ = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  always #5 clk = ~clk;

  logic              busy, done, csb1, out_valid, out_last;
  logic [7:0]        addr1, out_query;
  logic [1:0]        out_rank;
  logic [DW-1:0]     out_dist;
  logic [8:0]        out_index;
  logic [KK*DW-1:0]  rdist_1;
  logic [KK*9-1:0]   rindices_1;

  kbest_result_reader #(.DATA_WIDTH(DW), .K(KK), .NUM_QUERIES(NQ)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .csb1(csb1), .addr1(addr1), .rdist_1(rdist_1), .rindices_1(rindices_1),
    .out_valid(out_valid), .out_ready(out_ready), .out_query(out_query),
    .out_rank(out_rank), .out_dist(out_dist), .out_index(out_index),
    .out_last(out_last)
  );

  // Small instance: K=2, one query
  logic              start_s = 1'b0;
  logic              rdy_s = 1'b1;
  logic              busy_s, done_s, csb1_s, out_valid_s, out_last_s;
  logic [7:0]        addr1_s, out_query_s;
  logic [0:0]        out_rank_s;
  logic [DW-1:0]     out_dist_s;
  logic [8:0]        out_index_s;
  logic [2*DW-1:0]   rdist_s;
  logic [17:0]       ridx_s;

  kbest_result_reader #(.DATA_WIDTH(DW), .K(2), .NUM_QUERIES(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
    .csb1(csb1_s), .addr1(addr1_s), .rdist_1(rdist_s), .rindices_1(ridx_s),
    .out_valid(out_valid_s), .out_ready(rdy_s), .out_query(out_query_s),
    .out_rank(out_rank_s), .out_dist(out_dist_s), .out_index(out_index_s),
    .out_last(out_last_s)
  );

  // Array model: registered read on port 1
  logic [DW-1:0] mem_dist [NQ][KK];
  logic [8:0]    mem_idx  [NQ][KK];

  always @(posedge clk) begin
    if (!csb1) begin
      for (int s = 0; s < KK; s++) begin
        rdist_1[s*DW +: DW] <= mem_dist[addr1][s];
        rindices_1[s*9 +: 9] <= mem_idx[addr1][s];
      end
    end
    if (!csb1_s) begin
      for (int s = 0; s < 2; s++) begin
        rdist_s[s*DW +: DW] <= DW'(100 + s);
        ridx_s[s*9 +: 9]    <= 9'(7 + 3*s);
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int q; int r; int d; int i; bit last;
  } beat_t;
  beat_t sb[$];

  bit first_seen, expect_done, prev_stall, all_ready, pass_done;
  int start_cyc, read_cyc, last_cyc, csb_cnt, done_cnt, beat_no;
  int sv_q, sv_r, sv_d, sv_i, sv_l;

  // Monitor: pops the scoreboard on every accepted beat
  always @(negedge clk) begin
    if (rst_n) begin
      if (!csb1) begin
        if (csb_cnt == 0) read_cyc = cyc;
        csb_cnt++;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_query", out_query, sv_q);
        check("stall_rank", out_rank, sv_r);
        check("stall_dist", out_dist, sv_d);
        check("stall_index", out_index, sv_i);
        check("stall_last", out_last, sv_l);
      end
      if (out_valid) begin
        if (!first_seen) begin
          check("first_beat_latency", cyc - start_cyc, 3);
          first_seen = 1'b1;
        end
        if (out_ready) begin
          beat_no++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_overrun: got beat q=%0d r=%0d expected none", out_query, out_rank);
          end else begin
            beat_t e;
            e = sb.pop_front();
            check("beat_query", out_query, e.q);
            check("beat_rank", out_rank, e.r);
            check("beat_dist", out_dist, e.d);
            check("beat_index", out_index, e.i);
            check("beat_last", out_last, e.last);
            check("beat_busy", busy, 1);
            if (e.last) begin
              last_cyc = cyc;
              expect_done = 1'b1;
              if (all_ready) check("read_to_last_cycles", cyc - read_cyc + 1, NQ*(KK+2));
            end
          end
        end
      end
      if (done) begin
        check("done_expected", expect_done, 1);
        if (expect_done) check("done_timing", cyc, last_cyc + 1);
        check("busy_at_done", busy, 0);
        done_cnt++;
        expect_done = 1'b0;
        pass_done = 1'b1;
      end else if (expect_done && cyc > last_cyc) begin
        check("done_timing", 0, 1);
        expect_done = 1'b0;
        pass_done = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      sv_q = out_query; sv_r = out_rank; sv_d = out_dist;
      sv_i = out_index; sv_l = out_last;
    end
  end

  task automatic fill_mem(bit rule);
    for (int a = 0; a < NQ; a++)
      for (int s = 0; s < KK; s++) begin
        mem_dist[a][s] = rule ? DW'(a*4 + s) : DW'($urandom);
        mem_idx[a][s]  = rule ? 9'(a + s)    : 9'($urandom);
      end
  endtask

  task automatic arm_pass(bit rand_ready);
    csb_cnt = 0; done_cnt = 0; beat_no = 0;
    first_seen = 1'b0; pass_done = 1'b0; prev_stall = 1'b0;
    expect_done = 1'b0; all_ready = !rand_ready;
    for (int a = 0; a < NQ; a++)
      for (int s = 0; s < KK; s++) begin
        beat_t e;
        e.q = a; e.r = s; e.d = mem_dist[a][s]; e.i = mem_idx[a][s];
        e.last = (a == NQ-1) && (s == KK-1);
        sb.push_back(e);
      end
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_pass(bit rand_ready, bit spam);
    arm_pass(rand_ready);
    for (int n = 0; n < 20000 && !pass_done; n++) begin
      @(posedge clk); #1;
      // Extra starts only while busy or in the done cycle: both must be ignored
      start = spam && (busy || done) && ($urandom_range(0, 3) == 0);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!pass_done) check("pass_timeout", 0, 1);
    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", sb.size(), 0);
    check("beats_accepted", beat_no, NQ*KK);
    check("done_count", done_cnt, 1);
    check("csb1_count", csb_cnt, NQ);
    check("idle_after_pass", busy, 0);
  endtask

  initial begin
    #2;
    check("rst_csb1", csb1, 1);
    check("rst_addr1", addr1, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_query", out_query, 0);
    check("rst_out_rank", out_rank, 0);
    check("rst_out_dist", out_dist, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Small instance cycle-accurate walk
    begin
      int t;
      #1 start_s = 1'b1;
      t = cyc;
      @(posedge clk); #1 start_s = 1'b0;
      for (int k = 2; k <= 6; k++) begin
        @(negedge clk);
        check("small_cycle", cyc - t, k - 1 + ((k == 2) ? 0 : 0));
        case (k)
          2: begin check("small_busy_t1", busy_s, 1); check("small_csb_t1", csb1_s, 0); check("small_valid_t1", out_valid_s, 0); end
          3: begin check("small_csb_t2", csb1_s, 1); check("small_valid_t2", out_valid_s, 0); end
          4: begin check("small_valid_t3", out_valid_s, 1); check("small_rank_t3", out_rank_s, 0);
                   check("small_dist_t3", out_dist_s, 100); check("small_index_t3", out_index_s, 7);
                   check("small_last_t3", out_last_s, 0); check("small_query_t3", out_query_s, 0); end
          5: begin check("small_valid_t4", out_valid_s, 1); check("small_rank_t4", out_rank_s, 1);
                   check("small_dist_t4", out_dist_s, 101); check("small_index_t4", out_index_s, 10);
                   check("small_last_t4", out_last_s, 1); end
          6: begin check("small_done_t5", done_s, 1); check("small_busy_t5", busy_s, 0); check("small_valid_t5", out_valid_s, 0); end
          default: ;
        endcase
      end
      @(negedge clk);
      check("small_done_t6", done_s, 0);
    end

    // Pass 1: rule-based contents, ready always high
    fill_mem(1'b1);
    run_pass(1'b0, 1'b0);
    // Pass 2: random contents, random backpressure, repeated start pulses
    fill_mem(1'b0);
    run_pass(1'b1, 1'b1);

    // Pass 3: reset during SEND of query 17
    fill_mem(1'b0);
    arm_pass(1'b0);
    @(posedge clk); #1 start = 1'b0;
    begin
      bit hit = 1'b0;
      for (int n = 0; n < 400 && !hit; n++) begin
        @(negedge clk);
        hit = out_valid && (out_query == 8'd17);
      end
      check("reach_q17", hit, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_csb1", csb1, 1);
    check("arst_out_query", out_query, 0);
    check("arst_out_dist", out_dist, 0);
    check("arst_done", done, 0);
    sb.delete();
    expect_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_done", done, 0);
    check("post_reset_busy", busy, 0);
    // Pass 4: replay from q=0
    run_pass(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
